// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-port (loader/data/fetch) single-memory arbiter with fetch anti-starvation.
// Optional loader port enabled by defining MEM_ARBITER_LOADER_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_be,
    output logic        o_d_ack,
    output logic [31:0] o_d_rdata,
    input  logic        i_i_req,
    input  logic [31:0] i_i_addr,
    output logic        o_i_ack,
    output logic [31:0] o_i_rdata,
    input  logic        i_l_req,
    input  logic [31:0] i_l_addr,
    input  logic [31:0] i_l_wdata,
    output logic        o_l_ack,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {P_D, P_I, P_L} port_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    port_t       grant_q, grant_d, win;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_ack_q, d_ack_d;
    logic        i_ack_q, i_ack_d;
    logic        l_ack_q, l_ack_d;
    logic [3:0]  starve_q, starve_d;
    logic        l_req_eff;

`ifdef MEM_ARBITER_LOADER_EN
    assign l_req_eff = i_l_req;
    assign o_l_ack   = l_ack_q;
`else
    // Loader never wins here, so its ack flop stays at zero and the request is dead.
    logic unused_loader;
    assign l_req_eff     = 1'b0;
    assign o_l_ack       = 1'b0;
    assign unused_loader = i_l_req | l_ack_q;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        win         = P_D;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        d_rdata_d   = d_rdata_q;
        i_rdata_d   = i_rdata_q;
        d_ack_d     = 1'b0;
        i_ack_d     = 1'b0;
        l_ack_d     = 1'b0;
        starve_d    = starve_q;
        case (state_q)
            S_IDLE: begin
                if (l_req_eff || i_d_req || i_i_req) begin
                    if (i_i_req && starve_q == LIMIT) win = P_I;
                    else if (l_req_eff)               win = P_L;
                    else if (i_d_req)                 win = P_D;
                    else                              win = P_I;
                    state_d   = S_BUSY;
                    grant_d   = win;
                    mem_req_d = 1'b1;
                    case (win)
                        P_L: begin
                            mem_addr_d  = i_l_addr;
                            mem_wdata_d = i_l_wdata;
                            mem_we_d    = 1'b1;
                            mem_be_d    = 4'hF;
                        end
                        P_D: begin
                            mem_addr_d  = i_d_addr;
                            mem_wdata_d = i_d_wdata;
                            mem_we_d    = i_d_we;
                            mem_be_d    = i_d_be;
                        end
                        default: begin
                            mem_addr_d  = i_i_addr;
                            mem_wdata_d = 32'h0;
                            mem_we_d    = 1'b0;
                            mem_be_d    = 4'hF;
                        end
                    endcase
                    // Fetch loses only count while it is actually waiting.
                    if (win == P_I)                           starve_d = 4'd0;
                    else if (i_i_req && starve_q < LIMIT)     starve_d = starve_q + 4'd1;
                end
            end
            S_BUSY: begin
                if (i_mem_ack) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    case (grant_q)
                        P_D: begin
                            d_ack_d = 1'b1;
                            if (!mem_we_q) d_rdata_d = i_mem_rdata;
                        end
                        P_I: begin
                            i_ack_d   = 1'b1;
                            i_rdata_d = i_mem_rdata;
                        end
                        default: l_ack_d = 1'b1;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            grant_q     <= P_D;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            d_rdata_q   <= 32'h0;
            i_rdata_q   <= 32'h0;
            d_ack_q     <= 1'b0;
            i_ack_q     <= 1'b0;
            l_ack_q     <= 1'b0;
            starve_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            d_rdata_q   <= d_rdata_d;
            i_rdata_q   <= i_rdata_d;
            d_ack_q     <= d_ack_d;
            i_ack_q     <= i_ack_d;
            l_ack_q     <= l_ack_d;
            starve_q    <= starve_d;
        end
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_be    = mem_be_q;
    assign o_d_ack     = d_ack_q;
    assign o_d_rdata   = d_rdata_q;
    assign o_i_ack     = i_ack_q;
    assign o_i_rdata   = i_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost arbitrations after which the instruction port wins (range 1..15).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port i_d_req, input, 1, data-port (MEM stage) request, held until o_d_ack.
REQ-005 SHALL have port i_d_we, input, 1, data-port write enable.
REQ-006 SHALL have port i_d_addr, input, 32, data-port byte address.
REQ-007 SHALL have port i_d_wdata, input, 32, data-port write data.
REQ-008 SHALL have port i_d_be, input, 4, data-port byte enables.
REQ-009 SHALL have port o_d_ack, output, 1, one-cycle completion pulse for the data port.
REQ-010 SHALL have port o_d_rdata, output, 32, data-port read data, valid with o_d_ack and held until the next o_d_ack.
REQ-011 SHALL have port i_i_req, input, 1, instruction-fetch request, held until o_i_ack.
REQ-012 SHALL have port i_i_addr, input, 32, fetch address.
REQ-013 SHALL have port o_i_ack, output, 1, one-cycle completion pulse for the fetch port.
REQ-014 SHALL have port o_i_rdata, output, 32, fetched word, valid with o_i_ack and held until the next o_i_ack.
REQ-015 SHALL have port i_l_req, input, 1, loader write request, held until o_l_ack.
REQ-016 SHALL have port i_l_addr, input, 32, loader byte address.
REQ-017 SHALL have port i_l_wdata, input, 32, loader write data.
REQ-018 SHALL have port o_l_ack, output, 1, one-cycle completion pulse for the loader port.
REQ-019 SHALL have port o_mem_req, output, 1, memory request, high for the whole transaction.
REQ-020 SHALL have port o_mem_we, output, 1, memory write enable.
REQ-021 SHALL have port o_mem_addr, output, 32, memory address.
REQ-022 SHALL have port o_mem_wdata, output, 32, memory write data.
REQ-023 SHALL have port o_mem_be, output, 4, memory byte enables.
REQ-024 SHALL have port i_mem_ack, input, 1, memory completion; i_mem_rdata valid in the same cycle.
REQ-025 SHALL have port i_mem_rdata, input, 32, memory read data.

Function
REQ-026 SHALL implement FSM IDLE -> BUSY (any request present) -> DONE (i_mem_ack) -> IDLE (unconditional).
REQ-027 SHALL arbitrate only in IDLE; priority loader > data > fetch, except fetch is first when the starve counter equals STARVE_LIMIT.
REQ-028 SHALL register the winner's address, wdata, be and we on the IDLE->BUSY edge; a loader grant drives we=1, be=4'hF; a fetch grant drives we=0, be=4'hF.
REQ-029 SHALL drive all o_mem_* outputs from registers only, so o_mem_req rises one cycle after the winning request is seen in IDLE.
REQ-030 SHALL capture i_mem_rdata into the winner's rdata register on i_mem_ack and pulse that port's ack for exactly the DONE cycle; minimum request-to-ack latency is 2 cycles (ack in cycle N+2 for request in IDLE cycle N and i_mem_ack in N+1).
REQ-031 SHALL drop o_mem_req in DONE; i_mem_ack outside BUSY SHALL be ignored.
REQ-032 SHALL complete a granted transaction even if its requester deasserts req before ack.
REQ-033 SHALL increment the 4-bit starve counter (saturating at STARVE_LIMIT) on each grant to another port while i_i_req is high, and clear it on each fetch grant.
REQ-034 SHALL leave the rdata register of a write transaction unchanged.

Reset
REQ-035 SHALL, on i_rst low, immediately force state IDLE, starve counter 0, all ack outputs 0, all o_mem_* outputs 0, all rdata registers 32'h0; an in-flight transaction is abandoned and no ack is issued for it.
REQ-036 SHALL begin arbitration on the first rising edge after i_rst returns high.

Configuration
REQ-037 SHALL, with MEM_ARBITER_LOADER_EN defined, include the loader port and its top priority as above.
REQ-038 SHALL, without MEM_ARBITER_LOADER_EN, keep the loader ports but ignore i_l_req, tie o_l_ack to 0, and arbitrate data > fetch only.

Verification
REQ-039 Data read addr 32'h100, memory acks 1 cycle after o_mem_req with 32'hDEADBEEF -> o_d_ack pulses 1 cycle, o_d_rdata=32'hDEADBEEF, o_mem_we=0.
REQ-040 Data and fetch requesting together, continuous data requests -> data wins 4 times, fetch wins the 5th arbitration, counter returns to 0.
REQ-041 Loader, data and fetch requesting in the same IDLE cycle -> loader granted (o_mem_we=1, o_mem_be=4'hF); data granted next.
REQ-042 i_rst pulsed low while BUSY with i_mem_ack pending -> o_mem_req=0 the same cycle, no ack pulse, fetch request after reset serviced normally.
REQ-043 Build without MEM_ARBITER_LOADER_EN, i_l_req held high with data request -> data served, o_l_ack never asserts.
REQ-044 Spurious i_mem_ack in IDLE -> no ack outputs, no rdata change.
